// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - Load/store unit driving the byte-addressed data memory port.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned half/word accesses into byte beats.
module load_store_unit #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_func3,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
`ifdef LSU_MISALIGN_SPLIT_EN
    SPLIT  = 2'd2,
`endif
    RESP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              store_q, store_d;
  logic [2:0]        func3_q, func3_d;
  logic              req_ready_d, resp_valid_d, resp_err_d;
  logic              mem_read_d, mem_write_d;
  logic [31:0]       resp_rdata_d, mem_wdata_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [2:0]        mem_func3_d;
  logic              legal, aligned;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       asm_q, asm_d;
  logic [1:0]        k_q, k_d, k_next;
  logic              last_beat;
`endif

  // Data sits in the low bytes; the funct3 code selects width and extension.
  function automatic logic [31:0] ext_load(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0:    ext_load = {{24{d[7]}}, d[7:0]};
      3'd1:    ext_load = {{16{d[15]}}, d[15:0]};
      3'd4:    ext_load = {24'd0, d[7:0]};
      3'd5:    ext_load = {16'd0, d[15:0]};
      default: ext_load = d;
    endcase
  endfunction

  always_comb begin
    legal = req_store ? (req_func3 <= 3'd2) : ((req_func3 != 3'd3) && (req_func3 <= 3'd5));
    case (req_func3[1:0])
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~req_addr[0];
      default: aligned = (req_addr[1:0] == 2'b00);
    endcase
  end

  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    func3_d      = func3_q;
    req_ready_d  = req_ready;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata;
    resp_err_d   = resp_err;
    mem_read_d   = mem_read;
    mem_write_d  = mem_write;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    mem_func3_d  = mem_func3;
`ifdef LSU_MISALIGN_SPLIT_EN
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    asm_d     = asm_q;
    k_d       = k_q;
    k_next    = k_q + 2'd1;
    last_beat = (func3_q[1:0] == 2'd1) ? (k_q == 2'd1) : (k_q == 2'd3);
`endif
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          store_d     = req_store;
          func3_d     = req_func3;
          req_ready_d = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
          addr_d  = req_addr;
          wdata_d = req_wdata;
`endif
          if (legal && aligned) begin
            state_d     = ACCESS;
            mem_read_d  = ~req_store;
            mem_write_d = req_store;
            mem_addr_d  = req_addr;
            mem_func3_d = req_func3;
            mem_wdata_d = req_store ? req_wdata : 32'd0;
          end
`ifdef LSU_MISALIGN_SPLIT_EN
          else if (legal) begin
            state_d     = SPLIT;
            k_d         = 2'd0;
            asm_d       = 32'd0;
            mem_read_d  = ~req_store;
            mem_write_d = req_store;
            mem_addr_d  = req_addr;
            mem_func3_d = req_store ? 3'd0 : 3'd4;
            mem_wdata_d = req_store ? {24'd0, req_wdata[7:0]} : 32'd0;
          end
`endif
          else begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'd0;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d      = RESP;
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = store_q ? 32'd0 : ext_load(func3_q, mem_rdata);
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      SPLIT: begin
        if (mem_ack) begin
          asm_d[{k_q, 3'b000} +: 8] = mem_rdata[7:0];
          if (last_beat) begin
            state_d      = RESP;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = store_q ? 32'd0 : ext_load(func3_q, asm_d);
          end else begin
            // Strobe stays up; only address and byte lane advance.
            k_d         = k_next;
            mem_addr_d  = addr_q + ADDR_W'(k_next);
            mem_wdata_d = store_q ? {24'd0, wdata_q[{k_next, 3'b000} +: 8]} : 32'd0;
          end
        end
      end
`endif
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      store_q    <= 1'b0;
      func3_q    <= 3'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      mem_func3  <= 3'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
      addr_q  <= '0;
      wdata_q <= 32'd0;
      asm_q   <= 32'd0;
      k_q     <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      store_q    <= store_d;
      func3_q    <= func3_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      resp_err   <= resp_err_d;
      mem_read   <= mem_read_d;
      mem_write  <= mem_write_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      mem_func3  <= mem_func3_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      asm_q   <= asm_d;
      k_q     <= k_d;
`endif
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - Scoreboard bench for load_store_unit with a byte memory model.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  req_func3 = 3'd0;
  logic [11:0] req_addr = 12'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_wdata;
  logic [11:0] mem_addr;
  logic [2:0]  mem_func3;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(12)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct packed { logic [31:0] rdata; logic err; } exp_t;
  typedef struct packed { logic wr; logic [11:0] addr; logic [2:0] f3; logic [31:0] wdata; } beat_t;

  exp_t       exp_q[$];
  beat_t      beats[$];
  logic [7:0] mem [4096];
  int         tests = 0;
  int         fails = 0;
  int         wait_cycles = 0;

  task automatic mem_model();
    int          wcnt = 0;
    bit          active = 1'b0;
    beat_t       snap, cur;
    logic [11:0] a;
    int          sz;
    forever begin
      @(negedge clk);
      mem_rdata = $urandom;
      if (rst) begin
        mem_ack = 1'b0;
        active  = 1'b0;
      end else begin
        if (mem_ack) begin
          mem_ack = 1'b0;
          active  = 1'b0;
        end
        if (mem_read || mem_write) begin
          cur = '{wr: mem_write, addr: mem_addr, f3: mem_func3, wdata: mem_wdata};
          if (mem_read && mem_write) begin
            tests++; fails++;
            $display("FAIL strobe_exclusive got read=1 write=1, required at most one");
          end
          if (!active) begin
            active = 1'b1;
            wcnt   = 0;
            snap   = cur;
          end else begin
            tests++;
            if (cur !== snap || mem_read !== ~snap.wr) begin
              fails++;
              $display("FAIL strobe_stable got addr=%h f3=%0d wdata=%h, required addr=%h f3=%0d wdata=%h",
                       cur.addr, cur.f3, cur.wdata, snap.addr, snap.f3, snap.wdata);
            end
          end
          if (wcnt >= wait_cycles) begin
            sz = (mem_func3[1:0] == 2'd0) ? 1 : (mem_func3[1:0] == 2'd1) ? 2 : 4;
            for (int i = 0; i < 4; i++) begin
              a = mem_addr + 12'(i);
              mem_rdata[8*i +: 8] = mem[a];
            end
            if (mem_write) begin
              for (int i = 0; i < sz; i++) begin
                a = mem_addr + 12'(i);
                mem[a] = mem_wdata[8*i +: 8];
              end
            end
            beats.push_back(cur);
            mem_ack = 1'b1;
          end else begin
            wcnt++;
          end
        end else begin
          active = 1'b0;
        end
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && resp_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL resp_unexpected got rdata=%h err=%b, required no response", resp_rdata, resp_err);
        end else begin
          e = exp_q.pop_front();
          if (resp_rdata !== e.rdata || resp_err !== e.err) begin
            fails++;
            $display("FAIL resp_data got rdata=%h err=%b, required rdata=%h err=%b",
                     resp_rdata, resp_err, e.rdata, e.err);
          end
        end
      end
    end
  endtask

  // Drives one request, queues its expected response, returns latency and accept cycle.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [11:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee,
                        output int lat, output int acc);
    int n = 0;
    lat = -1;
    acc = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL req_ready_timeout got ready=0, required ready=1 within 20 cycles");
      return;
    end
    exp_q.push_back('{rdata: er, err: ee});
    req_valid = 1'b1; req_store = st; req_func3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    acc = int'($time / 10);
    #1;
    req_valid = 1'b0; req_addr = 12'($urandom); req_wdata = $urandom;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) begin
      tests++; fails++;
      $display("FAIL resp_timeout got no resp_valid, required one within 40 cycles");
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_store = 1'b1; req_func3 = 3'd2;
    req_addr = 12'h123; req_wdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_flags got ready,valid,err,rd,wr=%b, required 10000",
               {req_ready, resp_valid, resp_err, mem_read, mem_write});
    end
    tests++;
    if (resp_rdata !== 32'd0 || mem_addr !== 12'd0 || mem_wdata !== 32'd0 || mem_func3 !== 3'd0) begin
      fails++;
      $display("FAIL reset_data got rdata=%h addr=%h wdata=%h f3=%0d, required all 0",
               resp_rdata, mem_addr, mem_wdata, mem_func3);
    end
    req_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_aligned_load();
    int lat, acc;
    mem[12'h010] = 8'h21; mem[12'h011] = 8'h43; mem[12'h012] = 8'h65; mem[12'h013] = 8'h87;
    wait_cycles = 0;
    beats.delete();
    do_req(1'b0, 3'd2, 12'h010, 32'h0, 32'h8765_4321, 1'b0, lat, acc);
    tests++;
    if (lat != 2) begin
      fails++; $display("FAIL lw_latency got %0d, required 2", lat);
    end
    tests++;
    if (beats.size() != 1 || beats[0].wr !== 1'b0 || beats[0].addr !== 12'h010 || beats[0].f3 !== 3'd2) begin
      fails++; $display("FAIL lw_beat got %0d beats, required one read at 010 f3=2", beats.size());
    end
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      fails++; $display("FAIL lw_ready_after got ready=%b valid=%b, required ready=1 valid=0", req_ready, resp_valid);
    end
  endtask

  task automatic test_byte_stall();
    int lat, acc;
    mem[12'h002] = 8'h77; mem[12'h003] = 8'hF0;
    mem[12'h004] = 8'h00; mem[12'h005] = 8'h00; mem[12'h006] = 8'h00;
    wait_cycles = 3;
    beats.delete();
    do_req(1'b0, 3'd0, 12'h003, 32'h0, 32'hFFFF_FFF0, 1'b0, lat, acc);
    tests++;
    if (lat != 5) begin
      fails++; $display("FAIL lb_stall_latency got %0d, required 5", lat);
    end
    do_req(1'b0, 3'd4, 12'h003, 32'h0, 32'h0000_00F0, 1'b0, lat, acc);
    tests++;
    if (beats.size() != 2 || beats[0].addr !== 12'h003 || beats[0].f3 !== 3'd0 || beats[1].f3 !== 3'd4) begin
      fails++; $display("FAIL byte_beats got %0d beats, required reads at 003 f3=0 then f3=4", beats.size());
    end
    wait_cycles = 0;
  endtask

  task automatic test_half_load();
    int lat, acc;
    mem[12'h020] = 8'h34; mem[12'h021] = 8'hC2; mem[12'h022] = 8'h55; mem[12'h023] = 8'h66;
    wait_cycles = 0;
    do_req(1'b0, 3'd1, 12'h020, 32'h0, 32'hFFFF_C234, 1'b0, lat, acc);
    do_req(1'b0, 3'd5, 12'h020, 32'h0, 32'h0000_C234, 1'b0, lat, acc);
    do_req(1'b0, 3'd2, 12'h020, 32'h0, 32'h6655_C234, 1'b0, lat, acc);
    tests++;
    if (lat != 2) begin
      fails++; $display("FAIL half_latency got %0d, required 2", lat);
    end
  endtask

  task automatic test_store();
    int lat, acc;
    mem[12'h044] = 8'h00; mem[12'h046] = 8'h5A;
    wait_cycles = 0;
    beats.delete();
    do_req(1'b1, 3'd2, 12'h040, 32'h1122_3344, 32'h0, 1'b0, lat, acc);
    tests++;
    if (beats.size() != 1 || beats[0].wr !== 1'b1 || beats[0].f3 !== 3'd2 || beats[0].wdata !== 32'h1122_3344) begin
      fails++; $display("FAIL sw_beat got %0d beats, required one write f3=2 wdata=11223344", beats.size());
    end
    tests++;
    if ({mem[12'h043], mem[12'h042], mem[12'h041], mem[12'h040]} !== 32'h1122_3344) begin
      fails++; $display("FAIL sw_mem got %h%h%h%h, required 11223344",
                        mem[12'h043], mem[12'h042], mem[12'h041], mem[12'h040]);
    end
    do_req(1'b1, 3'd0, 12'h045, 32'hAABB_CCDD, 32'h0, 1'b0, lat, acc);
    tests++;
    if (mem[12'h045] !== 8'hDD || mem[12'h046] !== 8'h5A) begin
      fails++; $display("FAIL sb_mem got 045=%h 046=%h, required DD 5A", mem[12'h045], mem[12'h046]);
    end
    do_req(1'b1, 3'd1, 12'h046, 32'h0000_CAFE, 32'h0, 1'b0, lat, acc);
    do_req(1'b0, 3'd2, 12'h044, 32'h0, 32'hCAFE_DD00, 1'b0, lat, acc);
  endtask

  task automatic test_illegal();
    logic [3:0] tbl [8];
    int lat, acc;
    tbl = '{4'h3, 4'h6, 4'h7, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    for (int i = 0; i < 8; i++) begin
      beats.delete();
      do_req(tbl[i][3], tbl[i][2:0], 12'h100, 32'h1234_5678, 32'h0, 1'b1, lat, acc);
      tests++;
      if (lat != 1 || beats.size() != 0) begin
        fails++; $display("FAIL illegal_f3 store=%b f3=%0d got lat=%0d beats=%0d, required lat=1 beats=0",
                          tbl[i][3], tbl[i][2:0], lat, beats.size());
      end
    end
  endtask

`ifdef LSU_MISALIGN_SPLIT_EN
  task automatic test_misaligned();
    logic [31:0] d;
    int lat, acc;
    d = 32'hDEAD_BEEF;
    wait_cycles = 0;
    beats.delete();
    do_req(1'b1, 3'd2, 12'h005, d, 32'h0, 1'b0, lat, acc);
    tests++;
    if (lat != 5 || beats.size() != 4) begin
      fails++; $display("FAIL split_sw_shape got lat=%0d beats=%0d, required lat=5 beats=4", lat, beats.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (beats[i].wr !== 1'b1 || beats[i].addr !== 12'h005 + 12'(i) || beats[i].f3 !== 3'd0 ||
            beats[i].wdata[7:0] !== d[8*i +: 8]) begin
          fails++; $display("FAIL split_sw_beat%0d got addr=%h f3=%0d byte=%h, required addr=%h f3=0 byte=%h",
                            i, beats[i].addr, beats[i].f3, beats[i].wdata[7:0], 12'h005 + 12'(i), d[8*i +: 8]);
        end
      end
    end
    tests++;
    if ({mem[12'h008], mem[12'h007], mem[12'h006], mem[12'h005]} !== d) begin
      fails++; $display("FAIL split_sw_mem got %h%h%h%h, required %h",
                        mem[12'h008], mem[12'h007], mem[12'h006], mem[12'h005], d);
    end
    mem[12'hFFF] = 8'h80; mem[12'h000] = 8'h12;
    beats.delete();
    do_req(1'b0, 3'd1, 12'hFFF, 32'h0, 32'h0000_1280, 1'b0, lat, acc);
    tests++;
    if (lat != 3 || beats.size() != 2 || beats[0].addr !== 12'hFFF || beats[1].addr !== 12'h000 ||
        beats[0].f3 !== 3'd4 || beats[1].f3 !== 3'd4) begin
      fails++; $display("FAIL split_lh_wrap got lat=%0d beats=%0d, required lat=3 reads FFF,000 f3=4", lat, beats.size());
    end
    mem[12'hFFF] = 8'h34; mem[12'h000] = 8'hA5;
    do_req(1'b0, 3'd5, 12'hFFF, 32'h0, 32'h0000_A534, 1'b0, lat, acc);
    mem[12'h031] = 8'h01; mem[12'h032] = 8'h9F;
    do_req(1'b0, 3'd1, 12'h031, 32'h0, 32'hFFFF_9F01, 1'b0, lat, acc);
    mem[12'h101] = 8'h11; mem[12'h102] = 8'h22; mem[12'h103] = 8'h33; mem[12'h104] = 8'h44;
    wait_cycles = 1;
    do_req(1'b0, 3'd2, 12'h101, 32'h0, 32'h4433_2211, 1'b0, lat, acc);
    tests++;
    if (lat != 9) begin
      fails++; $display("FAIL split_lw_stall_latency got %0d, required 9", lat);
    end
    wait_cycles = 0;
  endtask
`else
  task automatic test_misaligned();
    int lat, acc;
    wait_cycles = 0;
    mem[12'h005] = 8'h66;
    beats.delete();
    do_req(1'b1, 3'd2, 12'h005, 32'hDEAD_BEEF, 32'h0, 1'b1, lat, acc);
    tests++;
    if (lat != 1 || beats.size() != 0 || mem[12'h005] !== 8'h66) begin
      fails++; $display("FAIL misaligned_sw got lat=%0d beats=%0d mem=%h, required lat=1 beats=0 mem=66",
                        lat, beats.size(), mem[12'h005]);
    end
    do_req(1'b0, 3'd1, 12'hFFF, 32'h0, 32'h0, 1'b1, lat, acc);
    do_req(1'b0, 3'd2, 12'h002, 32'h0, 32'h0, 1'b1, lat, acc);
    do_req(1'b0, 3'd5, 12'h001, 32'h0, 32'h0, 1'b1, lat, acc);
    do_req(1'b1, 3'd1, 12'h003, 32'h0, 32'h0, 1'b1, lat, acc);
    tests++;
    if (beats.size() != 0) begin
      fails++; $display("FAIL misaligned_no_strobe got %0d beats, required 0", beats.size());
    end
    do_req(1'b1, 3'd1, 12'h002, 32'h0000_BEEF, 32'h0, 1'b0, lat, acc);
    tests++;
    if (mem[12'h002] !== 8'hEF || mem[12'h003] !== 8'hBE) begin
      fails++; $display("FAIL aligned_sh got %h %h, required EF BE", mem[12'h002], mem[12'h003]);
    end
  endtask
`endif

  task automatic test_reset_abort();
    int n = 0;
    int lat, acc;
    logic [11:0] target;
    wait_cycles = 2;
    repeat (2) @(negedge clk);
`ifdef LSU_MISALIGN_SPLIT_EN
    req_func3 = 3'd1; req_addr = 12'h041; target = 12'h042;
`else
    req_func3 = 3'd2; req_addr = 12'h050; target = 12'h050;
`endif
    req_valid = 1'b1; req_store = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    while (!(mem_read && mem_addr == target) && n < 30) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!(mem_read && mem_addr == target)) begin
      fails++; $display("FAIL abort_reach got addr=%h read=%b, required read at %h", mem_addr, mem_read, target);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      fails++; $display("FAIL abort_state got rd=%b wr=%b ready=%b valid=%b, required 0 0 1 0",
                        mem_read, mem_write, req_ready, resp_valid);
    end
    rst = 1'b0;
    wait_cycles = 0;
    do_req(1'b0, 3'd2, 12'h010, 32'h0, 32'h8765_4321, 1'b0, lat, acc);
    tests++;
    if (lat != 2) begin
      fails++; $display("FAIL abort_recover_latency got %0d, required 2", lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat, a0, a1, a2;
    wait_cycles = 0;
    do_req(1'b0, 3'd2, 12'h010, 32'h0, 32'h8765_4321, 1'b0, lat, a0);
    do_req(1'b0, 3'd4, 12'h013, 32'h0, 32'h0000_0087, 1'b0, lat, a1);
    do_req(1'b0, 3'd0, 12'h013, 32'h0, 32'hFFFF_FF87, 1'b0, lat, a2);
    tests++;
    if (a1 - a0 != 3 || a2 - a1 != 3) begin
      fails++; $display("FAIL b2b_spacing got %0d,%0d cycles, required 3,3", a1 - a0, a2 - a1);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    fork
      mem_model();
      monitor();
    join_none
    test_reset();
    test_aligned_load();
    test_byte_stall();
    test_half_load();
    test_store();
    test_illegal();
    test_misaligned();
    test_reset_abort();
    test_back_to_back();
    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain got %0d pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
